pixel_window_fetch: RTL and testbench
=====================================

// Module: pixel_window_fetch
// PURPOSE
//  Responder end of the controller's start/done fetch protocol: services start_read, start_move, start_shift
//  by reading image pixels from memory into a 3x3 Sobel window and returning read_done/move_done/shift_done.
//  Tracks raster window position; raises all_done when the current window is the last of the image.
//  Sits between the Sobel controller FSM and the pixel memory port; window feeds the gradient datapath.
// PARAMETERS
//  IMG_W    16  image width in pixels (>=3)
//  IMG_H    16  image height in pixels (>=3)
//  PIX_W     8  pixel bit width
//  ADDR_W   16  memory address width; IMG_W*IMG_H <= 2**ADDR_W
// PORTS
//  clk          in   1        single clock, rising edge
//  rst          in   1        synchronous, active-high reset
//  start_read   in   1        level request; alone = initial window load, with start_move = column fetch
//  start_move   in   1        level request; qualifies start_read as column fetch
//  start_shift  in   1        level request; shift one window row left
//  mem_rd       out  1        memory read request, held until mem_rvalid
//  mem_addr     out  ADDR_W   pixel address = y*IMG_W + x, stable while mem_rd
//  mem_rdata    in   PIX_W    read data, valid with mem_rvalid
//  mem_rvalid   in   1        read completion; ignored when mem_rd low
//  read_done    out  1        1-cycle pulse: 9-pixel load complete
//  move_done    out  1        1-cycle pulse: one column-fetch request complete
//  shift_done   out  1        1-cycle pulse: one row shift complete
//  all_done     out  1        level: win_valid && window top-left at (IMG_W-3, IMG_H-3)
//  win_valid    out  1        window contents consistent (all 9 entries loaded)
//  win_flat     out  9*PIX_W  p[r][c] at bits [(r*3+c)*PIX_W +: PIX_W]
// BEHAVIOUR
//  Reset: all outputs 0, win_flat 0, wx=wy=0, row/col pointers 0, FSM IDLE; rst mid-op aborts, mem_rd drops next edge.
//  FSM: IDLE, LOAD_RD, SHIFT, MOVE_RD, RELOAD_RD, DONE, GAP.
//  IDLE accept priority: start_read&start_move -> MOVE_RD; start_read -> LOAD_RD; start_shift -> SHIFT;
//   start_shift together with start_read is a conflict: ignored, stay IDLE. Requests ignored while all_done=1 except LOAD.
//  LOAD_RD: clears all_done/win_valid, wx=wy=0; 9 reads row-major (r,c) at (wx+c, wy+r); read_done pulse after 9th rvalid.
//  Memory: one outstanding read; mem_rd/mem_addr registered; capture mem_rdata on the cycle mem_rvalid=1 (latency >=0 extra cycles).
//  SHIFT: single cycle, row k=shift_ptr: p[k][0]<=p[k][1], p[k][1]<=p[k][2]; shift_ptr wraps 2->0; shift_done pulse.
//  MOVE_RD (move_ptr=k): if wx+3 < IMG_W read (wx+3, wy+k) into p[k][2], move_done on rvalid;
//   after k=2: wx++, move_ptr wraps 0.
//  Row end (wx+3 == IMG_W) at k=0: RELOAD_RD, 9-read full reload at (0, wy+1), then wx=0, wy++, move_done;
//   k=1,2 at row end complete in 1 cycle, no memory access.
//  win_valid drops at op accept that alters the window, rises with the op's done pulse.
//  DONE drives the done pulse; GAP: one cycle, requests ignored (prevents re-issue on stale level).
//  Done-to-next-accept minimum 2 cycles. Done pulses mutually exclusive.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: parameter TIMEOUT_CYC (default 64), extra port mem_err out 1; if mem_rd held TIMEOUT_CYC
//   cycles without mem_rvalid: drop mem_rd, set sticky mem_err, no done pulse, return IDLE; cleared by rst or LOAD accept.
//  Undefined: no counter, no mem_err port; waits on mem_rvalid indefinitely.
// STRUCTURE
//  sobel_pkg: fetch_state_t enum, PIX_W default, win_idx(r,c) function, done-pulse width constant.
//  Sub-module pixel_addr_gen: holds wx/wy, computes mem_addr=(wy+r)*IMG_W+(wx+c), row-end/last-window flags.
// TESTING (IMG_W=IMG_H=5, mem[a]=a, rvalid latency 1 unless stated)
//  Load: start_read held 9 cycles -> 9 reads addr 0,1,2,5,6,7,10,11,12; read_done 1 pulse; win_flat row0={0,1,2}.
//  Shift+move: 3 shift reqs then 3 move reqs -> rows {1,2,3},{6,7,8},{11,12,13}; addrs 3,8,13; wx=1.
//  Row end: at wx=2, move k=0 -> reload addrs 5..17 pattern (5,6,7,10,11,12,15,16,17); k=1,2 no mem_rd; wy=1.
//  Last window: advance to (2,2) -> all_done=1 with win_valid; further moves get no done; start_read reloads, clears all_done.
//  Stall/reset: rvalid delayed 7 cycles -> mem_addr stable, no done early; rst mid-load -> all outputs 0 next cycle.
//  MEM_TIMEOUT_EN, TIMEOUT_CYC=4: rvalid withheld -> mem_err=1 after 4 cycles, mem_rd 0, no read_done.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel pixel-window fetch block.
//  fetch_state_t : responder FSM states
//  done_kind_t   : which done pulse the DONE state drives
//  win_idx(r,c)  : flat index of window entry p[r][c]
package sobel_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD_RD, ST_SHIFT, ST_MOVE_RD, ST_RELOAD_RD, ST_DONE, ST_GAP
  } fetch_state_t;

  typedef enum logic [1:0] {DK_NONE, DK_READ, DK_MOVE, DK_SHIFT} done_kind_t;

  localparam int PIX_W_DEF    = 8;
  localparam int DONE_PULSE_W = 1;

  function automatic logic [3:0] win_idx(input logic [1:0] r, input logic [1:0] c);
    return 4'(r) * 4'd3 + 4'(c);
  endfunction
endpackage

// File: rtl/pixel_window_fetch_if.sv
// Pixel memory read port.
//  mem_rd/mem_addr : request, held until mem_rvalid (driven by master)
//  mem_rdata/mem_rvalid : completion (driven by slave)
interface pixel_window_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int PIX_W  = 8
) ();
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rdata;
  logic              mem_rvalid;

  modport master (output mem_rd, mem_addr, input mem_rdata, mem_rvalid);
  modport slave  (input mem_rd, mem_addr, output mem_rdata, mem_rvalid);
endinterface

// File: rtl/pixel_addr_gen.sv
// Window position tracker and pixel address generator.
//  clk, rst  : clock, synchronous active-high reset
//  clr       : wx=wy=0 (window load)
//  inc_x     : wx++ (column move finished)
//  next_row  : wx=0, wy++ (row-end reload finished)
//  reload    : address base is (0, wy+1) instead of (wx, wy)
//  r, c      : offset inside the window (c=3 addresses the incoming column)
//  addr      : (ybase+r)*IMG_W + (xbase+c)
//  row_end   : window touches right image edge
//  last_win  : window top-left at (IMG_W-3, IMG_H-3)
module pixel_addr_gen #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc_x,
  input  logic              next_row,
  input  logic              reload,
  input  logic [1:0]        r,
  input  logic [1:0]        c,
  output logic [ADDR_W-1:0] addr,
  output logic              row_end,
  output logic              last_win
);
  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);

  logic [XW-1:0]     wx;
  logic [YW-1:0]     wy;
  logic [ADDR_W-1:0] xb, yb;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wx <= '0;
      wy <= '0;
    end else if (next_row) begin
      wx <= '0;
      wy <= wy + YW'(1);
    end else if (inc_x) begin
      wx <= wx + XW'(1);
    end
  end

  always_comb begin
    xb       = reload ? '0 : ADDR_W'(wx);
    yb       = reload ? ADDR_W'(wy) + ADDR_W'(1) : ADDR_W'(wy);
    addr     = (yb + ADDR_W'(r)) * ADDR_W'(IMG_W) + xb + ADDR_W'(c);
    row_end  = (int'(wx) + 3 == IMG_W);
    last_win = (int'(wx) == IMG_W - 3) && (int'(wy) == IMG_H - 3);
  end
endmodule

// File: rtl/pixel_window_fetch.sv
// Responder for the Sobel controller's start/done fetch protocol. Fills and
// slides a 3x3 pixel window from a single-outstanding-read memory port.
//  clk, rst                          : clock, synchronous active-high reset
//  start_read/start_move/start_shift : level requests (read alone = load,
//                                      read+move = column fetch, shift = row shift)
//  mem (master)                      : pixel memory read port
//  read_done/move_done/shift_done    : 1-cycle completion pulses
//  all_done                          : window valid and at the last image position
//  win_valid                         : all 9 window entries consistent
//  win_flat                          : p[r][c] at [(r*3+c)*PIX_W +: PIX_W]
//  mem_err (MEM_TIMEOUT_EN only)     : sticky read-timeout flag
// Build option MEM_TIMEOUT_EN: abort a read after TIMEOUT_CYC cycles without rvalid.
module pixel_window_fetch
  import sobel_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int ADDR_W = 16
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_read,
  input  logic                 start_move,
  input  logic                 start_shift,
  pixel_window_fetch_if.master mem,
  output logic                 read_done,
  output logic                 move_done,
  output logic                 shift_done,
  output logic                 all_done,
  output logic                 win_valid,
  output logic [9*PIX_W-1:0]   win_flat
`ifdef MEM_TIMEOUT_EN
  , output logic               mem_err
`endif
);
  fetch_state_t             state, state_nx;
  done_kind_t               kind;
  logic [1:0]               rd_r, rd_c, move_ptr, shift_ptr;
  logic                     skip_mv;
  logic [8:0][PIX_W-1:0]    win;
  logic                     row_end, last_win;
  logic [ADDR_W-1:0]        ag_addr;
  logic [1:0]               ag_r, ag_c;
  logic                     req_load, req_move, req_shift;
  logic                     acc_load, acc_move, acc_shift, mv_noop;
  logic                     rd_state, rd_fire, seq_last, rd_last, timeout;

  // shift together with read is a conflict and matches none of the requests
  assign req_load  = start_read && !start_move && !start_shift;
  assign req_move  = start_read &&  start_move && !start_shift;
  assign req_shift = start_shift && !start_read;

  // After a row-end reload the remaining k=1,2 column requests of that
  // column cycle have nothing left to fetch.
  assign mv_noop   = skip_mv || (row_end && move_ptr != 2'd0);

  assign acc_load  = (state == ST_IDLE) && req_load;
  assign acc_move  = (state == ST_IDLE) && req_move  && !all_done;
  assign acc_shift = (state == ST_IDLE) && req_shift && !all_done;

  assign rd_state  = (state == ST_LOAD_RD) || (state == ST_RELOAD_RD) || (state == ST_MOVE_RD);
  assign rd_fire   = rd_state && mem.mem_rd && mem.mem_rvalid;
  assign seq_last  = (rd_r == 2'd2) && (rd_c == 2'd2);
  assign rd_last   = rd_fire && ((state == ST_MOVE_RD) || seq_last);

  assign ag_r = (state == ST_MOVE_RD) ? move_ptr : rd_r;
  assign ag_c = (state == ST_MOVE_RD) ? 2'd3     : rd_c;

  pixel_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .clr      (acc_load),
    .inc_x    (rd_fire && (state == ST_MOVE_RD) && (move_ptr == 2'd2)),
    .next_row (rd_fire && (state == ST_RELOAD_RD) && seq_last),
    .reload   (state == ST_RELOAD_RD),
    .r        (ag_r),
    .c        (ag_c),
    .addr     (ag_addr),
    .row_end  (row_end),
    .last_win (last_win)
  );

  assign all_done   = win_valid && last_win;
  assign read_done  = (state == ST_DONE) && (kind == DK_READ);
  assign move_done  = (state == ST_DONE) && (kind == DK_MOVE);
  assign shift_done = (state == ST_DONE) && (kind == DK_SHIFT);
  assign win_flat   = win;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (acc_move)       state_nx = mv_noop ? ST_DONE : (row_end ? ST_RELOAD_RD : ST_MOVE_RD);
        else if (acc_load)  state_nx = ST_LOAD_RD;
        else if (acc_shift) state_nx = ST_SHIFT;
      end
      ST_LOAD_RD, ST_RELOAD_RD, ST_MOVE_RD: begin
        if (timeout)      state_nx = ST_IDLE;
        else if (rd_last) state_nx = ST_DONE;
      end
      ST_SHIFT: state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_GAP;
      ST_GAP:   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem.mem_rd   <= 1'b0;
      mem.mem_addr <= '0;
      win          <= '0;
      win_valid    <= 1'b0;
      kind         <= DK_NONE;
      rd_r         <= 2'd0;
      rd_c         <= 2'd0;
      move_ptr     <= 2'd0;
      shift_ptr    <= 2'd0;
      skip_mv      <= 1'b0;
    end else begin
      if (acc_load) begin
        kind      <= DK_READ;
        win_valid <= 1'b0;
        rd_r      <= 2'd0;
        rd_c      <= 2'd0;
      end
      if (acc_move) begin
        kind <= DK_MOVE;
        if (mv_noop) begin
          move_ptr <= (move_ptr == 2'd2) ? 2'd0 : move_ptr + 2'd1;
          if (move_ptr == 2'd2) skip_mv <= 1'b0;
        end else begin
          win_valid <= 1'b0;
          rd_r      <= 2'd0;
          rd_c      <= 2'd0;
        end
      end
      if (acc_shift) begin
        kind      <= DK_SHIFT;
        win_valid <= 1'b0;
      end

      // One outstanding read: issue when idle in a read state, retire on rvalid.
      if (rd_state) begin
        if (timeout) begin
          mem.mem_rd <= 1'b0;
        end else if (!mem.mem_rd) begin
          mem.mem_rd   <= 1'b1;
          mem.mem_addr <= ag_addr;
        end else if (mem.mem_rvalid) begin
          mem.mem_rd <= 1'b0;
          if (state == ST_MOVE_RD) begin
            win[win_idx(move_ptr, 2'd2)] <= mem.mem_rdata;
            move_ptr  <= (move_ptr == 2'd2) ? 2'd0 : move_ptr + 2'd1;
            win_valid <= 1'b1;
          end else begin
            win[win_idx(rd_r, rd_c)] <= mem.mem_rdata;
            if (rd_c == 2'd2) begin
              rd_c <= 2'd0;
              rd_r <= rd_r + 2'd1;
            end else begin
              rd_c <= rd_c + 2'd1;
            end
            if (seq_last) begin
              win_valid <= 1'b1;
              if (state == ST_RELOAD_RD) begin
                move_ptr <= 2'd1;
                skip_mv  <= 1'b1;
              end
            end
          end
        end
      end

      if (state == ST_SHIFT) begin
        win[win_idx(shift_ptr, 2'd0)] <= win[win_idx(shift_ptr, 2'd1)];
        win[win_idx(shift_ptr, 2'd1)] <= win[win_idx(shift_ptr, 2'd2)];
        shift_ptr <= (shift_ptr == 2'd2) ? 2'd0 : shift_ptr + 2'd1;
        win_valid <= 1'b1;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;

  assign timeout = mem.mem_rd && !mem.mem_rvalid && (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt  <= '0;
      mem_err <= 1'b0;
    end else begin
      if (acc_load)     mem_err <= 1'b0;
      else if (timeout) mem_err <= 1'b1;
      if (!mem.mem_rd || mem.mem_rvalid || timeout) to_cnt <= '0;
      else                                          to_cnt <= to_cnt + TW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_pixel_window_fetch.sv
module tb_pixel_window_fetch;
  localparam int W = 5, H = 5, PW = 8, AW = 16;

  logic clk = 1'b0, rst = 1'b1;
  logic start_read = 1'b0, start_move = 1'b0, start_shift = 1'b0;
  logic read_done, move_done, shift_done, all_done, win_valid;
  logic [9*PW-1:0] win_flat;
`ifdef MEM_TIMEOUT_EN
  logic mem_err;
`endif

  pixel_window_fetch_if #(.ADDR_W(AW), .PIX_W(PW)) mif ();

  pixel_window_fetch #(
    .IMG_W(W), .IMG_H(H), .PIX_W(PW), .ADDR_W(AW)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT_CYC(4)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .start_read(start_read), .start_move(start_move), .start_shift(start_shift),
    .mem(mif),
    .read_done(read_done), .move_done(move_done), .shift_done(shift_done),
    .all_done(all_done), .win_valid(win_valid), .win_flat(win_flat)
`ifdef MEM_TIMEOUT_EN
    , .mem_err(mem_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // memory model: mem[a] = a, rvalid after lat extra cycles
  int lat = 0, cnt = 0;
  bit hold = 0, stall_chk = 0, rd_seen = 0;
  logic [AW-1:0] hold_addr;
  logic [AW-1:0] addr_q[$];

  always @(posedge clk) begin
    if (mif.mem_rd) rd_seen = 1;
    if (rst) begin
      mif.mem_rvalid <= 1'b0;
      mif.mem_rdata  <= '0;
      cnt = 0;
    end else begin
      mif.mem_rvalid <= 1'b0;
      if (mif.mem_rd && !mif.mem_rvalid) begin
        if (cnt == 0) hold_addr = mif.mem_addr;
        else if (stall_chk) chk("addr_stable", mif.mem_addr, hold_addr);
        if (!hold && cnt >= lat) begin
          mif.mem_rvalid <= 1'b1;
          mif.mem_rdata  <= PW'(mif.mem_addr);
          cnt = 0;
          if (addr_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_read addr=%0d t=%0t", mif.mem_addr, $time);
          end else begin
            chk("rd_addr", mif.mem_addr, addr_q.pop_front());
          end
        end else begin
          cnt++;
        end
      end
    end
  end

  // scoreboard
  typedef struct {
    logic [2:0]  p;   // {read, move, shift}
    logic [71:0] w;
    logic        ad;
  } exp_t;
  exp_t exp_q[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (read_done || move_done || shift_done)) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done pulses=%b t=%0t", {read_done, move_done, shift_done}, $time);
      end else begin
        e = exp_q.pop_front();
        chk("done_kind", {read_done, move_done, shift_done}, e.p);
        chk("win_flat", win_flat, e.w);
        chk("all_done", all_done, e.ad);
        chk("win_valid", win_valid, 1);
      end
    end
  end

  // reference window model
  int m[3][3];
  int wx = 0, wy = 0, mptr = 0, sptr = 0;
  bit skip = 0;

  function automatic logic [71:0] pack_win();
    logic [71:0] w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) w[(r*3+c)*8 +: 8] = 8'(m[r][c]);
    return w;
  endfunction

  task automatic push_exp(input logic [2:0] p);
    exp_t e;
    e.p = p; e.w = pack_win(); e.ad = (wx == W - 3) && (wy == H - 3);
    exp_q.push_back(e);
  endtask

  task automatic model_load();
    wx = 0; wy = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        m[r][c] = r * W + c;
        addr_q.push_back(AW'(r * W + c));
      end
  endtask

  task automatic model_shift();
    m[sptr][0] = m[sptr][1];
    m[sptr][1] = m[sptr][2];
    sptr = (sptr + 1) % 3;
  endtask

  task automatic model_move();
    int k;
    k = mptr;
    if (skip || (wx + 3 == W && k != 0)) begin
      if (k == 2) skip = 0;
      mptr = (k + 1) % 3;
    end else if (wx + 3 == W) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          m[r][c] = (wy + 1 + r) * W + c;
          addr_q.push_back(AW'((wy + 1 + r) * W + c));
        end
      wx = 0; wy++; mptr = 1; skip = 1;
    end else begin
      m[k][2] = (wy + k) * W + wx + 3;
      addr_q.push_back(AW'((wy + k) * W + wx + 3));
      if (k == 2) wx++;
      mptr = (k + 1) % 3;
    end
  endtask

  // 0 = load, 1 = shift, 2 = move; holds the request until its done pulse
  task automatic run(input int kind);
    int d0;
    case (kind)
      0: begin model_load();  push_exp(3'b100); end
      1: begin model_shift(); push_exp(3'b001); end
      default: begin model_move(); push_exp(3'b010); end
    endcase
    @(posedge clk); #1;
    start_read  = (kind != 1);
    start_move  = (kind == 2);
    start_shift = (kind == 1);
    d0 = done_cnt;
    for (int i = 0; i < 300 && done_cnt == d0; i++) @(posedge clk);
    #1;
    chk("done_seen", done_cnt != d0, 1);
    start_read = 0; start_move = 0; start_shift = 0;
  endtask

  task automatic ign(input logic r, input logic mv, input logic s, input string nm);
    int d0;
    @(posedge clk); #1;
    rd_seen = 0; d0 = done_cnt;
    start_read = r; start_move = mv; start_shift = s;
    repeat (8) @(posedge clk);
    #1;
    start_read = 0; start_move = 0; start_shift = 0;
    repeat (2) @(posedge clk);
    #1;
    chk({nm, "_nodone"}, done_cnt - d0, 0);
    chk({nm, "_nord"}, rd_seen, 0);
  endtask

  task automatic col_cycle(input bit with_shift);
    if (with_shift) repeat (3) run(1);
    repeat (3) run(2);
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_mem_rd"}, mif.mem_rd, 0);
    chk({nm, "_mem_addr"}, mif.mem_addr, 0);
    chk({nm, "_dones"}, {read_done, move_done, shift_done}, 0);
    chk({nm, "_valid"}, {win_valid, all_done}, 0);
    chk({nm, "_win"}, win_flat, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 0;

    ign(1, 0, 1, "conflict");

    run(0);                       // rows {0,1,2},{5,6,7},{10,11,12}
    col_cycle(1);                 // rows {1,2,3},{6,7,8},{11,12,13}, wx=1
    col_cycle(1);                 // wx=2
    col_cycle(0);                 // row-end reload at (0,1), k=1,2 no-ops
    col_cycle(1);
    col_cycle(1);                 // wx=2, wy=1
    col_cycle(0);                 // reload at (0,2)
    col_cycle(1);
    col_cycle(1);                 // (2,2): last window
    chk("all_done_level", all_done, 1);

    ign(1, 1, 0, "move_at_end");
    ign(0, 0, 1, "shift_at_end");

    run(0);                       // reload clears all_done
    chk("all_done_after_load", all_done, 0);

    lat = 7; stall_chk = 1;
    run(0);
    stall_chk = 0; lat = 0;

    // reset in the middle of a load
    model_load();
    @(posedge clk); #1;
    start_read = 1;
    repeat (6) @(posedge clk);
    #1;
    rst = 1; start_read = 0;
    @(posedge clk); #1;
    chk_idle_outputs("midreset");
    addr_q.delete();
    @(posedge clk); #1;
    rst = 0;

`ifdef MEM_TIMEOUT_EN
    begin
      int d0;
      hold = 1; d0 = done_cnt;
      @(posedge clk); #1;
      start_read = 1;
      @(posedge clk); @(posedge clk); #1;
      start_read = 0;
      repeat (10) @(posedge clk);
      #1;
      chk("timeout_err", mem_err, 1);
      chk("timeout_rd", mif.mem_rd, 0);
      chk("timeout_nodone", done_cnt - d0, 0);
      chk("timeout_valid", win_valid, 0);
      hold = 0;
      addr_q.delete();
    end
`endif

    repeat (3) @(posedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("addr_q_empty", addr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
